// File: rtl/instr_mem_ctrl_if.sv
// instr_mem_ctrl_if: program-load and fetch signals between the boot loader/fetch stage and the instruction memory.
interface instr_mem_if #(
   parameter int INSTR_W = 9,
   parameter int ADDR_W  = 12,
   parameter int PC_W    = 32
);
   logic               load_start;
   logic               load_valid;
   logic [INSTR_W-1:0] load_data;
   logic               load_done;
   logic [ADDR_W:0]    load_count;
   logic               load_ovf;
   logic               fetch_req;
   logic [PC_W-1:0]    fetch_pc;
   logic               fetch_ready;
   logic               instr_valid;
   logic [INSTR_W-1:0] instr;
   logic [PC_W-1:0]    instr_pc;
   logic               pc_fault;
   modport master (
      output load_start, load_valid, load_data, load_done, fetch_req, fetch_pc,
      input  load_count, load_ovf, fetch_ready, instr_valid, instr, instr_pc, pc_fault
   );
   modport slave (
      input  load_start, load_valid, load_data, load_done, fetch_req, fetch_pc,
      output load_count, load_ovf, fetch_ready, instr_valid, instr, instr_pc, pc_fault
   );
endinterface

// File: rtl/instr_mem_ctrl.sv
// instr_mem_ctrl: runtime-loadable instruction memory with a pipelined, range-checked fetch port.
module instr_mem_ctrl #(
   parameter int                 INSTR_W   = 9,
   parameter int                 DEPTH     = 4096,
   parameter int                 ADDR_W    = $clog2(DEPTH),
   parameter int                 PC_W      = 32,
   parameter int                 RD_LAT    = 1,
   parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
   parameter string              INIT_FILE = ""
) (
   input logic       clk,
   input logic       rst_n,
   instr_mem_if.slave io_bus
);
   typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
   localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] LP_LEN0  = (INIT_FILE != "") ? LP_DEPTH : '0;
   localparam state_t          LP_ST0   = (INIT_FILE != "") ? RUN : IDLE;

   logic [INSTR_W-1:0] r_mem [DEPTH];
   state_t             r_state;
   logic [ADDR_W:0]    r_wr_ptr;
   logic [ADDR_W:0]    r_prog_len;
   logic               r_ovf;
   logic               r_v1;
   logic [PC_W-1:0]    r_pc1;
   logic [INSTR_W-1:0] r_i1;
   logic               r_f1;
   logic               w_room;
   logic               w_wr;
   logic               w_acc;
   logic               w_fault;
   logic [ADDR_W-1:0]  w_idx;

   assign w_room  = r_wr_ptr < LP_DEPTH;
   assign w_wr    = (r_state == LOAD) && !io_bus.load_start && io_bus.load_valid && w_room;
   assign w_acc   = (r_state == RUN) && io_bus.fetch_req && !io_bus.load_start;
   assign w_fault = io_bus.fetch_pc >= PC_W'(r_prog_len);
   assign w_idx   = io_bus.fetch_pc[ADDR_W-1:0];

   always_ff @(posedge clk)
      if (w_wr) r_mem[r_wr_ptr[ADDR_W-1:0]] <= io_bus.load_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= LP_ST0;
         r_wr_ptr   <= '0;
         r_prog_len <= LP_LEN0;
         r_ovf      <= 1'b0;
      end else if (io_bus.load_start) begin
         r_state  <= LOAD;
         r_wr_ptr <= '0;
         r_ovf    <= 1'b0;
      end else if (r_state == LOAD) begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + (ADDR_W+1)'(1);
         if (io_bus.load_valid && !w_room) r_ovf <= 1'b1;
         if (io_bus.load_done) begin
            r_state    <= RUN;
            r_prog_len <= r_wr_ptr + (ADDR_W+1)'(w_wr);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v1  <= 1'b0;
         r_pc1 <= '0;
         r_i1  <= '0;
         r_f1  <= 1'b0;
      end else begin
         r_v1 <= w_acc;
         if (w_acc) begin
            r_pc1 <= io_bus.fetch_pc;
            r_f1  <= w_fault;
            r_i1  <= w_fault ? NOP_INSTR : r_mem[w_idx];
         end
      end
   end

   generate
      if (RD_LAT == 2) begin : g_lat2
         logic               r_v2;
         logic [PC_W-1:0]    r_pc2;
         logic [INSTR_W-1:0] r_i2;
         logic               r_f2;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_v2  <= 1'b0;
               r_pc2 <= '0;
               r_i2  <= '0;
               r_f2  <= 1'b0;
            end else begin
               r_v2 <= r_v1 && !io_bus.load_start;
               if (r_v1 && !io_bus.load_start) begin
                  r_pc2 <= r_pc1;
                  r_i2  <= r_i1;
                  r_f2  <= r_f1;
               end
            end
         end
         assign io_bus.instr_valid = r_v2;
         assign io_bus.instr_pc    = r_pc2;
         assign io_bus.instr       = r_i2;
         assign io_bus.pc_fault    = r_f2;
      end else begin : g_lat1
         assign io_bus.instr_valid = r_v1;
         assign io_bus.instr_pc    = r_pc1;
         assign io_bus.instr       = r_i1;
         assign io_bus.pc_fault    = r_f1;
      end
   endgenerate

   assign io_bus.load_count  = r_wr_ptr;
   assign io_bus.load_ovf    = r_ovf;
   assign io_bus.fetch_ready = (r_state == RUN);
endmodule

// File: tb/tb_instr_mem_ctrl.sv
// tb_instr_mem_ctrl: drives a DEPTH=8/RD_LAT=1 and a DEPTH=4096/RD_LAT=2 instance with the same stimulus
// and checks responses against a queue of expected fetch results.
module tb_instr_mem_ctrl;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        ls, lv, ld, req;
   logic [8:0]  ldata;
   logic [31:0] pc;
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   instr_mem_if #(.INSTR_W(9), .ADDR_W(3),  .PC_W(32)) if_a ();
   instr_mem_if #(.INSTR_W(9), .ADDR_W(12), .PC_W(32)) if_b ();
   assign if_a.load_start = ls;
   assign if_a.load_valid = lv;
   assign if_a.load_data  = ldata;
   assign if_a.load_done  = ld;
   assign if_a.fetch_req  = req;
   assign if_a.fetch_pc   = pc;
   assign if_b.load_start = ls;
   assign if_b.load_valid = lv;
   assign if_b.load_data  = ldata;
   assign if_b.load_done  = ld;
   assign if_b.fetch_req  = req;
   assign if_b.fetch_pc   = pc;

   instr_mem_ctrl #(.DEPTH(8), .RD_LAT(1)) u_a (.clk(clk), .rst_n(rst_n), .io_bus(if_a));
   instr_mem_ctrl #(.RD_LAT(2))            u_b (.clk(clk), .rst_n(rst_n), .io_bus(if_b));

   typedef struct {
      int          dut;
      longint      due;
      logic [31:0] pc;
      logic [8:0]  instr;
      logic        fault;
   } exp_t;
   typedef struct {
      logic [31:0] pc;
      logic [8:0]  instr;
      logic        fault;
      logic        pa;
      logic        pb;
   } vec_t;

   exp_t sb[$];
   vec_t t2[5];
   vec_t t3[3];

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic mon(int k, logic v, logic [31:0] p, logic [8:0] i, logic f);
      int idx = -1;
      string n = (k == 0) ? "a" : "b";
      if (!v) return;
      foreach (sb[j]) if (idx < 0 && sb[j].dut == k) idx = j;
      if (idx < 0) begin
         total++;
         bad++;
         $display("FAIL stray_valid_%s: got response pc %h want none", n, p);
         return;
      end
      check({"resp_time_", n}, 32'($time), 32'(sb[idx].due));
      check({"resp_pc_", n}, p, sb[idx].pc);
      check({"resp_instr_", n}, 32'(i), 32'(sb[idx].instr));
      check({"resp_fault_", n}, 32'(f), 32'(sb[idx].fault));
      sb.delete(idx);
   endtask

   always @(negedge clk) begin
      mon(0, if_a.instr_valid, if_a.instr_pc, if_a.instr, if_a.pc_fault);
      mon(1, if_b.instr_valid, if_b.instr_pc, if_b.instr, if_b.pc_fault);
   end

   task automatic step(logic s, logic v, logic [8:0] d, logic dn, logic r, logic [31:0] p);
      @(negedge clk);
      ls = s; lv = v; ldata = d; ld = dn; req = r; pc = p;
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 9'h0, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic fetch(vec_t x);
      step(1'b0, 1'b0, 9'h0, 1'b0, 1'b1, x.pc);
      if (x.pa) sb.push_back('{dut: 0, due: longint'($time) + 10, pc: x.pc, instr: x.instr, fault: x.fault});
      if (x.pb) sb.push_back('{dut: 1, due: longint'($time) + 20, pc: x.pc, instr: x.instr, fault: x.fault});
   endtask

   task automatic chk_ctl(string tag, int ca, logic oa, int cb, logic ob, logic rdy);
      check({tag, "_count_a"}, 32'(if_a.load_count), 32'(ca));
      check({tag, "_ovf_a"},   32'(if_a.load_ovf), 32'(oa));
      check({tag, "_count_b"}, 32'(if_b.load_count), 32'(cb));
      check({tag, "_ovf_b"},   32'(if_b.load_ovf), 32'(ob));
      check({tag, "_ready_a"}, 32'(if_a.fetch_ready), 32'(rdy));
      check({tag, "_ready_b"}, 32'(if_b.fetch_ready), 32'(rdy));
   endtask

   task automatic drain(string tag);
      repeat (4) idle();
      check({tag, "_drain"}, 32'(sb.size()), 32'd0);
      sb.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      t2 = '{'{32'd0, 9'h011, 1'b0, 1'b1, 1'b1},
             '{32'd1, 9'h022, 1'b0, 1'b1, 1'b1},
             '{32'd2, 9'h033, 1'b0, 1'b1, 1'b1},
             '{32'd3, 9'h000, 1'b1, 1'b1, 1'b1},
             '{32'h1000_0000, 9'h000, 1'b1, 1'b1, 1'b1}};
      t3 = '{'{32'd0, 9'h100, 1'b0, 1'b1, 1'b1},
             '{32'd7, 9'h107, 1'b0, 1'b1, 1'b1},
             '{32'h0000_0108, 9'h000, 1'b1, 1'b1, 1'b1}};
      rst_n = 1'b0; ls = 0; lv = 0; ld = 0; req = 0; ldata = '0; pc = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      // T1: out of reset with no image
      check("t1_valid_a", 32'(if_a.instr_valid), 32'd0);
      check("t1_valid_b", 32'(if_b.instr_valid), 32'd0);
      chk_ctl("t1", 0, 1'b0, 0, 1'b0, 1'b0);
      // T2: three-word load, done on the last word
      step(1'b1, 1'b0, 9'h0, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b1, 9'h011, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b1, 9'h022, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b1, 9'h033, 1'b1, 1'b0, 32'h0);
      idle();
      chk_ctl("t2", 3, 1'b0, 3, 1'b0, 1'b1);
      foreach (t2[i]) fetch(t2[i]);
      drain("t2");
      // T3: ten words; the small instance overflows after eight
      step(1'b1, 1'b0, 9'h0, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 9'(9'h100 + i), i == 9, 1'b0, 32'h0);
      idle();
      chk_ctl("t3", 8, 1'b1, 10, 1'b0, 1'b1);
      foreach (t3[i]) fetch(t3[i]);
      drain("t3");
      // T4: load_start while fetches are in flight in the two-stage instance
      fetch('{32'd0, 9'h100, 1'b0, 1'b1, 1'b0});
      step(1'b1, 1'b0, 9'h0, 1'b0, 1'b1, 32'd1);
      idle();
      chk_ctl("t4_load", 0, 1'b0, 0, 1'b0, 1'b0);
      repeat (3) idle();
      check("t4_hold_ready_a", 32'(if_a.fetch_ready), 32'd0);
      check("t4_hold_ready_b", 32'(if_b.fetch_ready), 32'd0);
      step(1'b0, 1'b1, 9'h055, 1'b1, 1'b0, 32'h0);
      idle();
      chk_ctl("t4_run", 1, 1'b0, 1, 1'b0, 1'b1);
      fetch('{32'd0, 9'h055, 1'b0, 1'b1, 1'b1});
      drain("t4");
      // T5: asynchronous reset in the middle of a load
      step(1'b1, 1'b0, 9'h0, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b1, 9'h1AA, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b1, 9'h1BB, 1'b0, 1'b0, 32'h0);
      idle();
      check("t5_pre_count_a", 32'(if_a.load_count), 32'd2);
      #2 rst_n = 1'b0;
      #1;
      chk_ctl("t5_rst", 0, 1'b0, 0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 1'b0, 9'h0, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b1, 9'h0CC, 1'b1, 1'b0, 32'h0);
      idle();
      chk_ctl("t5", 1, 1'b0, 1, 1'b0, 1'b1);
      fetch('{32'd0, 9'h0CC, 1'b0, 1'b1, 1'b1});
      fetch('{32'd1, 9'h000, 1'b1, 1'b1, 1'b1});
      drain("t5");
      check("t5_mem1_a", 32'(u_a.r_mem[1]), 32'h1BB);
      check("t5_mem1_b", 32'(u_b.r_mem[1]), 32'h1BB);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
